vga_cell_mapper: RTL

Sequential, parametrised successor to the combinational pixel-to-cell adapter. It tracks the VGA raster with incremental counters, with no comparator chains, and emits per pixel:
- cell column/row,
- sub-cell pixel offsets,
- a linear video-memory address.

It sits between the VGA timing generator and the cell-memory read port.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_axis_div.sv | 48 ++++
 rtl/vga_cell_mapper.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA cell-mapping blocks.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_CELLS_X  = 16;
  localparam int VGA_CELLS_Y  = 12;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_div.sv
// Two-level wrap counter: pixel offset inside a cell, then cell index along one axis.
module vga_axis_div
  import vga_pkg::*;
#(
  parameter int  CELL  = 40,
  parameter int  CELLS = 16,
  localparam int SUB_W = clog2(CELL),
  localparam int IDX_W = clog2(CELLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  output logic [SUB_W-1:0] sub,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  logic [SUB_W-1:0] r_sub;
  logic [IDX_W-1:0] r_idx;
  logic             w_sub_last;
  logic             w_idx_last;

  assign w_sub_last = (r_sub == SUB_W'(CELL - 1));
  assign w_idx_last = (r_idx == IDX_W'(CELLS - 1));
  assign wrap       = step & w_sub_last & w_idx_last;
  assign sub        = r_sub;
  assign idx        = r_idx;

  // clear wins over step so a frame restart discards the pending advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_sub <= '0;
      r_idx <= '0;
    end else if (step) begin
      if (w_sub_last) begin
        r_sub <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_cell_mapper.sv
// Maps the VGA raster to cell column/row, sub-cell offsets and a linear cell address.
// Optional grid-overlay output enabled by defining VGA_CELL_MAPPER_BORDER_EN.
module vga_cell_mapper
  import vga_pkg::*;
#(
  parameter int  H_ACTIVE = VGA_H_ACTIVE,
  parameter int  V_ACTIVE = VGA_V_ACTIVE,
  parameter int  CELLS_X  = VGA_CELLS_X,
  parameter int  CELLS_Y  = VGA_CELLS_Y,
  localparam int CELL_W   = H_ACTIVE / CELLS_X,
  localparam int CELL_H   = V_ACTIVE / CELLS_Y,
  localparam int CX_W     = clog2(CELLS_X),
  localparam int CY_W     = clog2(CELLS_Y),
  localparam int SX_W     = clog2(CELL_W),
  localparam int SY_W     = clog2(CELL_H),
  localparam int ADDR_W   = clog2(CELLS_X * CELLS_Y)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              de,
  input  logic              frame_start,
  output logic [CX_W-1:0]   cell_x,
  output logic [CY_W-1:0]   cell_y,
  output logic [SX_W-1:0]   sub_x,
  output logic [SY_W-1:0]   sub_y,
  output logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  output logic              frame_done
`ifdef VGA_CELL_MAPPER_BORDER_EN
  ,
  output logic              border
`endif
);

  logic              w_active;
  logic [SX_W-1:0]   w_h_sub;
  logic [CX_W-1:0]   w_h_idx;
  logic              w_h_wrap;
  logic [SY_W-1:0]   w_v_sub;
  logic [CY_W-1:0]   w_v_idx;
  logic              w_v_wrap;
  logic              w_v_sub_last;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_row_base;
  logic [CX_W-1:0]   r_cell_x;
  logic [CY_W-1:0]   r_cell_y;
  logic [SX_W-1:0]   r_sub_x;
  logic [SY_W-1:0]   r_sub_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_out_valid;
  logic              r_frame_done;

  assign w_active = pix_en & de;

  vga_axis_div #(.CELL(CELL_W), .CELLS(CELLS_X)) u_h_div (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_active),
    .clear (frame_start),
    .sub   (w_h_sub),
    .idx   (w_h_idx),
    .wrap  (w_h_wrap)
  );

  // The vertical axis advances once per completed line.
  vga_axis_div #(.CELL(CELL_H), .CELLS(CELLS_Y)) u_v_div (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_h_wrap),
    .clear (frame_start),
    .sub   (w_v_sub),
    .idx   (w_v_idx),
    .wrap  (w_v_wrap)
  );

  assign w_v_sub_last = (w_v_sub == SY_W'(CELL_H - 1));
  assign w_addr       = r_row_base + ADDR_W'(w_h_idx);

  // row_base tracks cell_y*CELLS_X by accumulation, stepping on each cell-row change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base <= '0;
    end else if (frame_start || w_v_wrap) begin
      r_row_base <= '0;
    end else if (w_h_wrap && w_v_sub_last) begin
      r_row_base <= r_row_base + ADDR_W'(CELLS_X);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cell_x     <= '0;
      r_cell_y     <= '0;
      r_sub_x      <= '0;
      r_sub_y      <= '0;
      r_addr       <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (w_active) begin
      r_cell_x     <= w_h_idx;
      r_cell_y     <= w_v_idx;
      r_sub_x      <= w_h_sub;
      r_sub_y      <= w_v_sub;
      r_addr       <= w_addr;
      r_out_valid  <= 1'b1;
      r_frame_done <= w_v_wrap;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign cell_x     = r_cell_x;
  assign cell_y     = r_cell_y;
  assign sub_x      = r_sub_x;
  assign sub_y      = r_sub_y;
  assign addr       = r_addr;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

`ifdef VGA_CELL_MAPPER_BORDER_EN
  logic w_border;
  logic r_border;

  assign w_border = (w_h_sub == '0) || (w_h_sub == SX_W'(CELL_W - 1)) ||
                    (w_v_sub == '0) || w_v_sub_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_border <= 1'b0;
    end else begin
      r_border <= w_active & w_border;
    end
  end

  assign border = r_border;
`endif

endmodule
